register_scan_reader: RTL and testbench
=======================================

Name: register_scan_reader

Overview:
- Read-side master of the register-file port. It owns the check_R side of multiplexRegisterFile and drives that mux's selector input.
- On each start pulse from the print/VGA path, it walks the sprite registers in ascending order. It reads each one through the shared port and compares it against the current pixel position.
- It reports the first register whose sprite covers the pixel.
- It yields the port to the instruction decoder whenever a write is pending.

Parameters:
- NUM_REGS, 32, registers in the file; the scan ends at NUM_REGS-1.
- FIRST_REG, 1, first register scanned; register 0 is reserved.
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- SPRITE_SIZE, 20, sprite edge length in pixels (square).

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a scan for pixel_x/pixel_y.
- pixel_x  in  10  current pixel column, sampled on the accepted start.
- pixel_y  in  10  current pixel row, sampled on the accepted start.
- write_pending  in  1  decoder requests the register port.
- reg_data  in  DATA_W  register-file read data; valid the cycle after check_R is presented.
- selector  out  1  mux select: 0 = scanner owns the port, 1 = decoder owns it.
- check_R  out  ADDR_W  register index being read.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at the end of a scan.
- hit  out  1  a sprite covers the pixel; valid from done until the next accepted start.
- hit_reg  out  ADDR_W  index of the first covering register.
- hit_data  out  DATA_W  contents of that register.

Behaviour:
- Reset values:
  - state IDLE
  - selector=1
  - check_R=0
  - busy=0, done=0, hit=0
  - hit_reg=0, hit_data=0
  - latched pixel = 0
- Register data format:
  - [31] active
  - [28:19] x origin
  - [18:9] y origin
  - [8:0] sprite memory offset (passed through, unused here)
- Coverage rule:
  - A register covers the pixel when active=1 AND x <= px <= x+SIZE-1 AND y <= py <= y+SIZE-1.
  - The sums are computed in 11 bits, so an origin near 1023 does not wrap.
- FSM states:
  - IDLE: selector=1, busy=0. On start, latch pixel_x/pixel_y, clear hit/hit_reg/hit_data, set check_R=FIRST_REG, go to ADDR.
  - ADDR:
    - If write_pending=1: selector=1, stay in ADDR (stall; check_R held).
    - Else: selector=0, go to READ.
  - READ:
    - selector=0. write_pending is ignored this cycle; the read completes.
    - Compare reg_data. On coverage: capture hit=1, hit_reg=check_R, hit_data=reg_data, go to DONE.
    - Else if check_R==NUM_REGS-1: go to DONE with hit=0.
    - Else: check_R+1, go to ADDR.
  - DONE: done=1 for exactly one cycle, selector=1, busy=0 next; go to IDLE.
- busy is high in ADDR, READ and DONE.
- start outside IDLE is ignored. Results from the last scan stay stable in IDLE.
- Priority: the lowest index wins; the scan stops at the first hit.
- Latency with no stalls: done is high in the cycle after edge 2*(r-FIRST_REG+1) following the start edge.
  - Hit at register r=5: done after edge 10.
  - Full miss: done after edge 62.
  - Each stall cycle adds 1.
- Inactive registers (bit31=0) never hit, whatever their coordinates.
- Reset mid-scan: immediate return to IDLE with all reset values, selector=1. No done pulse.
- start and write_pending together in IDLE: start is accepted; the first ADDR cycle then stalls.

Decomposition:
- Shared package register_scan_pkg:
  - state enum (IDLE, ADDR, READ, DONE)
  - field bit positions (ACTIVE_BIT, X_MSB/LSB, Y_MSB/LSB, OFFSET_MSB/LSB)
  - default SPRITE_SIZE
  - the constants SEL_DECODER=1 and SEL_PRINT=0, which the mux also uses
- One natural sub-module: sprite_hit_compare.
  - Combinational.
  - Inputs: reg_data, px, py.
  - Output: covers.

Test Plan:
1. Reset mid-scan (reset asserted in READ of reg 7) → next cycle IDLE, selector=1, busy=0, no done pulse; hit=0.
2. Only reg 5 active with x=100, y=50, pixel (110,60) → done 10 cycles after start, hit=1, hit_reg=5, hit_data = reg 5 contents; check_R never exceeds 5.
3. Regs 3 and 9 both covering (200,200), start → hit_reg=3, done after edge 6.
4. All regs inactive, or pixel (119,60) vs reg 5 (x=100: 100+19=119 hits, so use (120,60)) → hit=0, done after edge 62, check_R reaches 31.
5. write_pending held 3 cycles during ADDR of reg 2 → selector=1 during those cycles, check_R stays 2, done delayed by exactly 3 cycles; write_pending raised in READ → selector stays 0 that cycle.
6. Reg 1 with x=1020, y=0, pixel (1023,5) → hit=1 (no 10-bit wrap); second start while busy → ignored, single done pulse.

Source files
------------

// File: rtl/register_scan_pkg.sv
// Shared types and constants for the sprite register scanner and the register-file mux.
package register_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    // Sprite register layout
    localparam int ACTIVE_BIT = 31;
    localparam int X_MSB      = 28;
    localparam int X_LSB      = 19;
    localparam int Y_MSB      = 18;
    localparam int Y_LSB      = 9;
    localparam int OFFSET_MSB = 8;
    localparam int OFFSET_LSB = 0;

    localparam int DEFAULT_SPRITE_SIZE = 20;

    // Mux selector encoding shared with multiplexRegisterFile
    localparam logic SEL_DECODER = 1'b1;
    localparam logic SEL_PRINT   = 1'b0;

endpackage

// File: rtl/register_scan_reader_hit_compare.sv
// Combinational test of whether one sprite register covers a pixel.
module sprite_hit_compare
    import register_scan_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SPRITE_SIZE = DEFAULT_SPRITE_SIZE
) (
    input  logic [DATA_W-1:0] reg_data,
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    output logic              covers
);

    localparam logic [10:0] SPAN = 11'(SPRITE_SIZE - 1);

    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        unused_bits;

    // 11-bit sums keep origins near 1023 from wrapping back to column 0
    assign x0    = {1'b0, reg_data[X_MSB:X_LSB]};
    assign y0    = {1'b0, reg_data[Y_MSB:Y_LSB]};
    assign x_end = x0 + SPAN;
    assign y_end = y0 + SPAN;

    assign in_x   = ({1'b0, px} >= x0) && ({1'b0, px} <= x_end);
    assign in_y   = ({1'b0, py} >= y0) && ({1'b0, py} <= y_end);
    assign covers = reg_data[ACTIVE_BIT] && in_x && in_y;

    assign unused_bits = ^{reg_data[DATA_W-1:ACTIVE_BIT+1], reg_data[ACTIVE_BIT-1:X_MSB+1],
                           reg_data[OFFSET_MSB:OFFSET_LSB]};

endmodule

// File: rtl/register_scan_reader.sv
// Scans sprite registers through the shared register-file port and reports the first one covering the pixel.
module register_scan_reader
    import register_scan_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int FIRST_REG   = 1,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int SPRITE_SIZE = DEFAULT_SPRITE_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              write_pending,
    input  logic [DATA_W-1:0] reg_data,
    output logic              selector,
    output logic [ADDR_W-1:0] check_R,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [ADDR_W-1:0] hit_reg,
    output logic [DATA_W-1:0] hit_data,
    output logic [1:0]        dbg_state
);

    // Port handshake: check_R is presented in ADDR while selector=SEL_PRINT; the
    // addressed word arrives on reg_data in the following READ cycle. A pending
    // write only holds off ADDR; a READ that has started always completes.

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] check_r_q, check_r_d;
    logic [9:0]        px_q, px_d;
    logic [9:0]        py_q, py_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] hit_reg_q, hit_reg_d;
    logic [DATA_W-1:0] hit_data_q, hit_data_d;
    logic              covers;

    sprite_hit_compare #(
        .DATA_W      (DATA_W),
        .SPRITE_SIZE (SPRITE_SIZE)
    ) u_compare (
        .reg_data (reg_data),
        .px       (px_q),
        .py       (py_q),
        .covers   (covers)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            check_r_q  <= '0;
            px_q       <= '0;
            py_q       <= '0;
            hit_q      <= 1'b0;
            hit_reg_q  <= '0;
            hit_data_q <= '0;
        end else begin
            state_q    <= state_d;
            check_r_q  <= check_r_d;
            px_q       <= px_d;
            py_q       <= py_d;
            hit_q      <= hit_d;
            hit_reg_q  <= hit_reg_d;
            hit_data_q <= hit_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        check_r_d  = check_r_q;
        px_d       = px_q;
        py_d       = py_q;
        hit_d      = hit_q;
        hit_reg_d  = hit_reg_q;
        hit_data_d = hit_data_q;
        selector   = SEL_DECODER;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    px_d       = pixel_x;
                    py_d       = pixel_y;
                    hit_d      = 1'b0;
                    hit_reg_d  = '0;
                    hit_data_d = '0;
                    check_r_d  = FIRST_IDX;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (!write_pending) begin
                    selector = SEL_PRINT;
                    state_d  = READ;
                end
            end
            READ: begin
                selector = SEL_PRINT;
                if (covers) begin
                    hit_d      = 1'b1;
                    hit_reg_d  = check_r_q;
                    hit_data_d = reg_data;
                    state_d    = DONE;
                end else if (check_r_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    check_r_d = check_r_q + 1'b1;
                    state_d   = ADDR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign check_R   = check_r_q;
    assign busy      = (state_q != IDLE);
    assign hit       = hit_q;
    assign hit_reg   = hit_reg_q;
    assign hit_data  = hit_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_register_scan_reader.sv
// Directed bench for register_scan_reader with a synchronous-read register file model and a result scoreboard.
module tb_register_scan_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        write_pending = 1'b0;
    logic [31:0] reg_data = '0;
    logic        selector;
    logic [4:0]  check_R;
    logic        busy;
    logic        done;
    logic        hit;
    logic [4:0]  hit_reg;
    logic [31:0] hit_data;
    logic [1:0]  dbg_state;

    logic [31:0] regs [32];
    logic [44:0] exp_q [$];   // {hit, hit_reg, hit_data, latency[6:0]}
    int          n_checks = 0;
    int          n_fail = 0;

    register_scan_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .write_pending (write_pending),
        .reg_data      (reg_data),
        .selector      (selector),
        .check_R       (check_R),
        .busy          (busy),
        .done          (done),
        .hit           (hit),
        .hit_reg       (hit_reg),
        .hit_data      (hit_data),
        .dbg_state     (dbg_state)
    );

    // clock / register file model
    always #5 clk = ~clk;

    always @(posedge clk) reg_data <= regs[check_R];

    function automatic logic [31:0] mk(input logic act, input logic [9:0] x, input logic [9:0] y,
                                       input logic [8:0] off);
        return {act, 2'b00, x, y, off};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 1: write_pending stalls ADDR of reg 2 for 3 cycles, then pulses in READ of reg 2
    // mode 2: a second start arrives while the scan is busy
    task automatic run_scan(input string name, input logic [9:0] px, input logic [9:0] py,
                            input logic e_hit, input logic [4:0] e_reg, input int e_lat,
                            input int mode);
        logic [44:0] exp;
        logic [4:0]  max_r;
        logic        seen;
        exp_q.push_back({e_hit, e_reg, (e_hit ? regs[e_reg] : 32'h0), 7'(e_lat)});
        @(negedge clk);
        pixel_x = px;
        pixel_y = py;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        pixel_x = 10'($urandom_range(0, 1023));
        pixel_y = 10'($urandom_range(0, 1023));
        max_r   = '0;
        seen    = 1'b0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mode == 1) write_pending = ((n >= 2) && (n <= 4)) || (n == 6);
            if (mode == 2) start = (n == 1);
            #1;
            if (mode == 1 && n >= 2 && n <= 4) begin
                check({name, "_stall_sel"}, 64'(selector), 64'd1);
                check({name, "_stall_chk"}, 64'(check_R), 64'd2);
            end
            if (mode == 1 && n == 6) check({name, "_read_sel"}, 64'(selector), 64'd0);
            if (check_R > max_r) max_r = check_R;
            if (done) begin
                seen = 1'b1;
                exp  = exp_q.pop_front();
                check({name, "_hit"}, 64'(hit), 64'(exp[44]));
                check({name, "_hit_reg"}, 64'(hit_reg), 64'(exp[43:39]));
                check({name, "_hit_data"}, 64'(hit_data), 64'(exp[38:7]));
                check({name, "_latency"}, 64'(n), 64'(exp[6:0]));
            end
        end
        write_pending = 1'b0;
        start         = 1'b0;
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_max_check_R"}, 64'(max_r), 64'(e_hit ? e_reg : 5'd31));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check({name, "_done_single"}, 64'(done), 64'd0);
            check({name, "_idle_busy"}, 64'(busy), 64'd0);
            check({name, "_stable_hit"}, 64'(hit), 64'(e_hit));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_selector", 64'(selector), 64'd1);
        check("rst_check_R", 64'(check_R), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_hit_reg", 64'(hit_reg), 64'd0);
        check("rst_hit_data", 64'(hit_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // single active register 5
        regs[5] = mk(1'b1, 10'd100, 10'd50, 9'h1a5);
        run_scan("reg5", 10'd110, 10'd60, 1'b1, 5'd5, 10, 0);

        // two covering registers: lowest index wins
        regs[3] = mk(1'b1, 10'd190, 10'd195, 9'h033);
        regs[9] = mk(1'b1, 10'd200, 10'd200, 9'h099);
        run_scan("prio", 10'd200, 10'd200, 1'b1, 5'd3, 6, 0);

        // reset asserted while reading register 7
        @(negedge clk);
        pixel_x = 10'd500;
        pixel_y = 10'd500;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (13) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("mid_state_read", 64'(dbg_state), 64'd2);
        check("mid_check_R", 64'(check_R), 64'd7);
        reset = 1'b1;
        #1;
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_selector", 64'(selector), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_check_R", 64'(check_R), 64'd0);
        check("mid_rst_hit", 64'(hit), 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("mid_rst_no_done", 64'(done), 64'd0);
        end
        reset = 1'b0;

        // miss: pixel one column past reg 5, and inactive reg 10 placed over the pixel
        regs[10] = mk(1'b0, 10'd110, 10'd55, 9'h010);
        run_scan("miss", 10'd120, 10'd60, 1'b0, 5'd0, 62, 0);

        // stall on write_pending during ADDR of reg 2
        run_scan("stall", 10'd110, 10'd60, 1'b1, 5'd5, 13, 1);

        // right-edge origin with no wrap, plus start while busy
        regs[1] = mk(1'b1, 10'd1020, 10'd0, 9'h1ff);
        run_scan("edge", 10'd1023, 10'd5, 1'b1, 5'd1, 2, 2);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
